uart_cmd_parse: RTL and testbench
=================================

// Module: uart_cmd_parse
// PURPOSE
//  Sits directly downstream of uart_rx, consuming its rx_data/rx_data_rdy byte stream.
//  Parses ASCII commands of the form "*W<addr><data><CR>" (write) and "*R<addr><CR>" (read).
//  Each valid command produces a one-cycle strobe with the decoded address/data, which
//  drives the wave-generator register and sample-RAM logic. Malformed input raises an error strobe.
// PARAMETERS
//  ADDR_DIGITS   2       hex digits of address; cmd_addr width = 4*ADDR_DIGITS
//  DATA_DIGITS   4       hex digits of data; cmd_data width = 4*DATA_DIGITS
//  TIMEOUT_CYC   0       clk_rx cycles allowed between bytes inside a command; 0 = no timeout
// PORTS
//  clk_rx        in   1               receive-domain clock
//  rst_clk_rx    in   1               asynchronous, active-high reset
//  rx_data       in   8               byte from uart_rx, valid when rx_data_rdy=1
//  rx_data_rdy   in   1               one-cycle byte-valid strobe from uart_rx
//  cmd_wr        out  1               one-cycle write strobe
//  cmd_rd        out  1               one-cycle read strobe
//  cmd_addr      out  4*ADDR_DIGITS   decoded address; held until the next strobe
//  cmd_data      out  4*DATA_DIGITS   decoded write data; held until the next cmd_wr
//  cmd_err       out  1               one-cycle strobe on a syntax error or timeout
//  busy          out  1               1 while a command is partially received (state != IDLE)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, digit counter=0, shift registers=0. Reset is async, mid-command
//   reset discards the partial command with no strobe.
//  Bytes are evaluated only in cycles with rx_data_rdy=1; other cycles hold state (except timeout).
//  Hex digit: '0'-'9', 'A'-'F', 'a'-'f' (case-insensitive). Nibble shifted in MSB-first.
//  FSM:
//   IDLE : '*' -> CMD. Any other byte is ignored silently (no cmd_err).
//   CMD  : 'W'/'w' -> ADDR (op=WR); 'R'/'r' -> ADDR (op=RD); '*' -> CMD; else err -> IDLE.
//   ADDR : hex -> shift into addr_sr, cnt++; at cnt==ADDR_DIGITS-1 go DATA (WR) or TERM (RD).
//   DATA : hex -> shift into data_sr, cnt++; at cnt==DATA_DIGITS-1 -> TERM.
//   TERM : 0x0D -> issue strobe, -> IDLE. Else err.
//   In CMD/ADDR/DATA/TERM, '*' is never an error: it restarts at CMD (cnt=0, shift regs kept
//   but are overwritten). Any other invalid byte: cmd_err=1 for one cycle, -> IDLE.
//  Strobe timing: cmd_wr/cmd_rd/cmd_err are registered, asserted in the cycle after the
//   rx_data_rdy cycle that completed or broke the command (latency 1). Never more than one of
//   cmd_wr/cmd_rd/cmd_err is high at once.
//  cmd_addr (and cmd_data on write) update in the same cycle the strobe is asserted; cmd_data is
//   unchanged by a read. Partial commands never disturb cmd_addr/cmd_data.
//  Timeout (TIMEOUT_CYC>0): counter clears on every rx_data_rdy and when in IDLE; if it reaches
//   TIMEOUT_CYC while state!=IDLE -> cmd_err pulse, -> IDLE. If a byte arrives in the same cycle
//   as expiry, the byte takes priority (counter clears, byte is processed normally).
//  Back-to-back bytes on consecutive cycles are supported (rx_data_rdy may be high every cycle).
//  busy=1 in all states other than IDLE, registered with the state.
// TESTING
//  1 Send "*W1A BEEF"\r without the space ("*W1ABEEF",0x0D) -> one cmd_wr pulse, cmd_addr=0x1A,
//    cmd_data=0xBEEF, cmd_err stays 0, busy falls on the same edge.
//  2 "*r3c",0x0D after test 1 -> one cmd_rd pulse, cmd_addr=0x3C, cmd_data still 0xBEEF.
//  3 "*W1G..." -> cmd_err pulses the cycle after 'G', FSM in IDLE; subsequent "*W0000FF",0x0D ->
//    cmd_wr with addr=0x00, data=0x00FF.
//  4 "*W12*R34",0x0D -> single cmd_rd with addr=0x34, no cmd_err, no cmd_wr.
//  5 TIMEOUT_CYC=100: send "*W1" then idle 100 cycles -> exactly one cmd_err, busy returns to 0;
//    idle in IDLE for 1000 cycles -> no cmd_err.
//  6 Assert rst_clk_rx asynchronously mid-"*W12AB" -> all outputs 0 immediately, no strobe after
//    release; stray bytes "xyz" in IDLE -> no cmd_err.

Source files
------------

// File: rtl/uart_cmd_parse.sv
// ASCII command parser behind uart_rx: decodes "*W<addr><data>\r" and "*R<addr>\r"
// into one-cycle write/read strobes, with an error strobe for malformed input or timeout.
module uart_cmd_parse #(
  parameter int ADDR_DIGITS = 2,
  parameter int DATA_DIGITS = 4,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                       i_clk_rx,
  input  logic                       i_rst_clk_rx,
  input  logic [7:0]                 i_rx_data,
  input  logic                       i_rx_data_rdy,
  output logic                       o_cmd_wr,
  output logic                       o_cmd_rd,
  output logic [4*ADDR_DIGITS-1:0]   o_cmd_addr,
  output logic [4*DATA_DIGITS-1:0]   o_cmd_data,
  output logic                       o_cmd_err,
  output logic                       o_busy
);

  localparam int AW   = 4*ADDR_DIGITS;
  localparam int DW   = 4*DATA_DIGITS;
  localparam int MAXD = (ADDR_DIGITS > DATA_DIGITS) ? ADDR_DIGITS : DATA_DIGITS;
  localparam int CW   = (MAXD > 1) ? $clog2(MAXD) : 1;
  localparam int TW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_DIGITS-1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_DIGITS-1);
  localparam logic [TW-1:0] TIME_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC-1) : '0;

  localparam logic [7:0] CH_STAR = 8'h2A;
  localparam logic [7:0] CH_CR   = 8'h0D;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_TERM} state_t;

  state_t          r_state, w_state_nx;
  logic            r_op_wr, w_op_wr_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic [AW-1:0]   r_addr_sr, w_addr_sr_nx;
  logic [DW-1:0]   r_data_sr, w_data_sr_nx;
  logic [TW-1:0]   r_tcnt, w_tcnt_nx;
  logic            w_wr_nx, w_rd_nx, w_err_nx;
  logic [AW-1:0]   w_addr_out_nx;
  logic [DW-1:0]   w_data_out_nx;
  logic            w_is_hex;
  logic [3:0]      w_nib;

  always_comb begin
    w_is_hex = 1'b0;
    w_nib    = 4'h0;
    if (i_rx_data >= 8'h30 && i_rx_data <= 8'h39) begin
      w_is_hex = 1'b1;
      w_nib    = i_rx_data[3:0];
    end else if ((i_rx_data >= 8'h41 && i_rx_data <= 8'h46) ||
                 (i_rx_data >= 8'h61 && i_rx_data <= 8'h66)) begin
      w_is_hex = 1'b1;
      w_nib    = i_rx_data[3:0] + 4'd9;
    end
  end

  // A '*' restarts the command from any state; an expiring timeout loses to an arriving byte.
  always_comb begin
    w_state_nx    = r_state;
    w_op_wr_nx    = r_op_wr;
    w_cnt_nx      = r_cnt;
    w_addr_sr_nx  = r_addr_sr;
    w_data_sr_nx  = r_data_sr;
    w_tcnt_nx     = '0;
    w_wr_nx       = 1'b0;
    w_rd_nx       = 1'b0;
    w_err_nx      = 1'b0;
    w_addr_out_nx = o_cmd_addr;
    w_data_out_nx = o_cmd_data;
    if (i_rx_data_rdy) begin
      if (i_rx_data == CH_STAR) begin
        w_state_nx = S_CMD;
        w_cnt_nx   = '0;
      end else begin
        case (r_state)
          S_IDLE: ;
          S_CMD: begin
            if (i_rx_data == 8'h57 || i_rx_data == 8'h77) begin
              w_state_nx = S_ADDR;
              w_op_wr_nx = 1'b1;
              w_cnt_nx   = '0;
            end else if (i_rx_data == 8'h52 || i_rx_data == 8'h72) begin
              w_state_nx = S_ADDR;
              w_op_wr_nx = 1'b0;
              w_cnt_nx   = '0;
            end else begin
              w_err_nx   = 1'b1;
              w_state_nx = S_IDLE;
            end
          end
          S_ADDR: begin
            if (w_is_hex) begin
              w_addr_sr_nx = (r_addr_sr << 4) | AW'(w_nib);
              if (r_cnt == ADDR_LAST) begin
                w_cnt_nx   = '0;
                w_state_nx = r_op_wr ? S_DATA : S_TERM;
              end else begin
                w_cnt_nx = r_cnt + CW'(1);
              end
            end else begin
              w_err_nx   = 1'b1;
              w_state_nx = S_IDLE;
            end
          end
          S_DATA: begin
            if (w_is_hex) begin
              w_data_sr_nx = (r_data_sr << 4) | DW'(w_nib);
              if (r_cnt == DATA_LAST) begin
                w_cnt_nx   = '0;
                w_state_nx = S_TERM;
              end else begin
                w_cnt_nx = r_cnt + CW'(1);
              end
            end else begin
              w_err_nx   = 1'b1;
              w_state_nx = S_IDLE;
            end
          end
          S_TERM: begin
            if (i_rx_data == CH_CR) begin
              w_wr_nx       = r_op_wr;
              w_rd_nx       = ~r_op_wr;
              w_addr_out_nx = r_addr_sr;
              if (r_op_wr) w_data_out_nx = r_data_sr;
            end else begin
              w_err_nx = 1'b1;
            end
            w_state_nx = S_IDLE;
          end
          default: w_state_nx = S_IDLE;
        endcase
      end
    end else if (r_state != S_IDLE && TIMEOUT_CYC > 0) begin
      if (r_tcnt == TIME_LAST) begin
        w_err_nx   = 1'b1;
        w_state_nx = S_IDLE;
      end else begin
        w_tcnt_nx = r_tcnt + TW'(1);
      end
    end
  end

  always_ff @(posedge i_clk_rx or posedge i_rst_clk_rx) begin
    if (i_rst_clk_rx) begin
      r_state    <= S_IDLE;
      r_op_wr    <= 1'b0;
      r_cnt      <= '0;
      r_addr_sr  <= '0;
      r_data_sr  <= '0;
      r_tcnt     <= '0;
      o_cmd_wr   <= 1'b0;
      o_cmd_rd   <= 1'b0;
      o_cmd_err  <= 1'b0;
      o_cmd_addr <= '0;
      o_cmd_data <= '0;
      o_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_op_wr    <= w_op_wr_nx;
      r_cnt      <= w_cnt_nx;
      r_addr_sr  <= w_addr_sr_nx;
      r_data_sr  <= w_data_sr_nx;
      r_tcnt     <= w_tcnt_nx;
      o_cmd_wr   <= w_wr_nx;
      o_cmd_rd   <= w_rd_nx;
      o_cmd_err  <= w_err_nx;
      o_cmd_addr <= w_addr_out_nx;
      o_cmd_data <= w_data_out_nx;
      o_busy     <= (w_state_nx != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_cmd_parse.sv
// Self-checking bench for uart_cmd_parse: directed command scenarios plus random byte streams,
// compared every cycle against a string-level reference parser.
module tb_uart_cmd_parse;

  localparam int TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rxData = 8'h00;
  logic        rxRdy = 1'b0;
  logic        cmdWr, cmdRd, cmdErr, busy;
  logic [7:0]  cmdAddr;
  logic [15:0] cmdData;

  int checkCount = 0;
  int errCount = 0;
  bit checkEn = 1'b0;

  uart_cmd_parse #(.ADDR_DIGITS(2), .DATA_DIGITS(4), .TIMEOUT_CYC(TIMEOUT)) dut (
    .i_clk_rx(clk), .i_rst_clk_rx(rst), .i_rx_data(rxData), .i_rx_data_rdy(rxRdy),
    .o_cmd_wr(cmdWr), .o_cmd_rd(cmdRd), .o_cmd_addr(cmdAddr), .o_cmd_data(cmdData),
    .o_cmd_err(cmdErr), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: remembers the text since the last '*' and judges each new byte against it.
  bit          mActive = 1'b0;
  byte         mBuf[$];
  int          mIdle = 0;
  logic        expWr = 1'b0, expRd = 1'b0, expErr = 1'b0, expBusy = 1'b0;
  logic [7:0]  expAddr = 8'h00;
  logic [15:0] expData = 16'h0000;

  function automatic bit isHex(input byte c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
  endfunction

  function automatic int hexVal(input byte c);
    if (c >= "0" && c <= "9") return c - "0";
    if (c >= "A" && c <= "F") return c - "A" + 10;
    return c - "a" + 10;
  endfunction

  task automatic modelByte(input byte b);
    bit isW, isR, bad, done;
    int pos, nDig;
    bad = 0;
    done = 0;
    if (b == "*") begin
      mActive = 1;
      mBuf.delete();
    end else if (mActive) begin
      mBuf.push_back(b);
      pos  = mBuf.size();
      isW  = (mBuf[0] == "W" || mBuf[0] == "w");
      isR  = (mBuf[0] == "R" || mBuf[0] == "r");
      nDig = isW ? 6 : 2;
      if (!(isW || isR)) bad = 1;
      else if (pos == 1) bad = 0;
      else if (pos <= nDig + 1) bad = !isHex(b);
      else if (b == 8'h0D) done = 1;
      else bad = 1;
      if (bad) begin
        expErr = 1;
        mActive = 0;
      end
      if (done) begin
        expAddr = 8'(hexVal(mBuf[1]) * 16 + hexVal(mBuf[2]));
        if (isW) begin
          expData = 16'(hexVal(mBuf[3]) * 4096 + hexVal(mBuf[4]) * 256 +
                        hexVal(mBuf[5]) * 16 + hexVal(mBuf[6]));
          expWr = 1;
        end else begin
          expRd = 1;
        end
        mActive = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mActive = 0; mBuf.delete(); mIdle = 0;
      expWr = 0; expRd = 0; expErr = 0; expBusy = 0; expAddr = 0; expData = 0;
    end else begin
      expWr = 0; expRd = 0; expErr = 0;
      if (rxRdy) begin
        mIdle = 0;
        modelByte(rxData);
      end else if (mActive) begin
        mIdle++;
        if (mIdle >= TIMEOUT) begin
          expErr = 1;
          mActive = 0;
          mIdle = 0;
        end
      end else begin
        mIdle = 0;
      end
      expBusy = mActive;
    end
  end

  initial forever begin
    @(negedge clk);
    if (checkEn) begin
      checkOutput("cyc_wr", 32'(cmdWr), 32'(expWr));
      checkOutput("cyc_rd", 32'(cmdRd), 32'(expRd));
      checkOutput("cyc_err", 32'(cmdErr), 32'(expErr));
      checkOutput("cyc_busy", 32'(busy), 32'(expBusy));
      checkOutput("cyc_addr", 32'(cmdAddr), 32'(expAddr));
      checkOutput("cyc_data", 32'(cmdData), 32'(expData));
    end
  end

  // Called just after a rising edge; presents one byte for one cycle, then idles 'gap' cycles.
  task automatic applyStimulus(input byte b, input int gap);
    rxData = b;
    rxRdy  = 1'b1;
    @(posedge clk); #1;
    rxRdy  = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic sendText(input string s, input bit withCr);
    for (int i = 0; i < s.len(); i++) applyStimulus(s[i], 0);
    if (withCr) applyStimulus(8'h0D, 0);
  endtask

  task automatic randomCommand();
    byte   q[$];
    string hx = "0123456789abcdefABCDEF";
    int    kind, nDig, idx, cut;
    kind = $urandom_range(0, 9);
    nDig = (kind < 5 || kind == 7) ? 6 : 2;
    q.push_back("*");
    if (nDig == 6) q.push_back(($urandom_range(0, 1) != 0) ? "W" : "w");
    else q.push_back(($urandom_range(0, 1) != 0) ? "R" : "r");
    for (int i = 0; i < nDig; i++) q.push_back(hx[$urandom_range(0, 21)]);
    q.push_back(8'h0D);
    if (kind == 7) begin
      idx = $urandom_range(1, q.size() - 1);
      q[idx] = byte'($urandom_range(32, 126));
    end else if (kind == 8) begin
      q.delete();
      for (int i = 0; i < 3; i++) q.push_back(byte'($urandom_range(32, 126)));
    end else if (kind == 9) begin
      cut = $urandom_range(1, q.size() - 1);
      for (int i = 0; i < cut; i++) q.push_back(q[i]);
    end
    foreach (q[i]) applyStimulus(q[i], ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    if ($urandom_range(0, 19) == 0) begin
      applyStimulus("*", 0);
      applyStimulus("W", TIMEOUT + 5);
    end else begin
      repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outs", {cmdWr, cmdRd, cmdErr, busy, 4'h0, cmdAddr, cmdData}, 32'h0);
    checkEn = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;

    sendText("*W1ABEEF", 1);
    checkOutput("t1_wr", 32'(cmdWr), 32'h1);
    checkOutput("t1_addr", 32'(cmdAddr), 32'h1A);
    checkOutput("t1_data", 32'(cmdData), 32'hBEEF);
    checkOutput("t1_busy", 32'(busy), 32'h0);

    sendText("*r3c", 1);
    checkOutput("t2_rd", 32'(cmdRd), 32'h1);
    checkOutput("t2_addr", 32'(cmdAddr), 32'h3C);
    checkOutput("t2_data", 32'(cmdData), 32'hBEEF);

    sendText("*W1G", 0);
    checkOutput("t3_err", 32'(cmdErr), 32'h1);
    checkOutput("t3_busy", 32'(busy), 32'h0);
    sendText("*W0000FF", 1);
    checkOutput("t3_wr", 32'(cmdWr), 32'h1);
    checkOutput("t3_addr", 32'(cmdAddr), 32'h00);
    checkOutput("t3_data", 32'(cmdData), 32'h00FF);

    sendText("*W12*R34", 1);
    checkOutput("t4_rd", 32'(cmdRd), 32'h1);
    checkOutput("t4_wr", 32'(cmdWr), 32'h0);
    checkOutput("t4_addr", 32'(cmdAddr), 32'h34);
    checkOutput("t4_data", 32'(cmdData), 32'h00FF);

    sendText("*W1", 0);
    n = 0;
    for (int i = 0; i < TIMEOUT + 5; i++) begin
      if (cmdErr) n++;
      @(posedge clk); #1;
    end
    checkOutput("t5_timeout_errs", 32'(n), 32'd1);
    checkOutput("t5_busy", 32'(busy), 32'h0);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      if (cmdErr) n++;
      @(posedge clk); #1;
    end
    checkOutput("t5_idle_errs", 32'(n), 32'd0);

    for (int i = 0; i < 150; i++) randomCommand();

    sendText("*WA5C3D2", 1);
    checkOutput("t6_pre_addr", 32'(cmdAddr), 32'hA5);
    sendText("*W12A", 0);
    #3 rst = 1'b1;
    #1;
    checkOutput("t6_rst_outs", {cmdWr, cmdRd, cmdErr, busy, 4'h0, cmdAddr, cmdData}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    sendText("B", 1);
    checkOutput("t6_no_wr", 32'(cmdWr), 32'h0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(byte'(8'h78 + i), 0);
      if (cmdErr) n++;
    end
    checkOutput("t6_stray_errs", 32'(n), 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'h0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
